// File: rtl/sdram_aref_if.sv
// Handshake and command bus between the SDRAM auto-refresh block and its arbiter.
// The refresh block attaches through the slave modport; the arbiter/bench uses master.
interface sdram_aref_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  init_end;
    logic                  aref_en;
    logic                  aref_req;
    logic                  aref_end;
    logic [3:0]            aref_cmd;
    logic [ADDR_WIDTH-1:0] aref_addr;

    modport master (
        output init_end,
        output aref_en,
        input  aref_req,
        input  aref_end,
        input  aref_cmd,
        input  aref_addr
    );

    modport slave (
        input  init_end,
        input  aref_en,
        output aref_req,
        output aref_end,
        output aref_cmd,
        output aref_addr
    );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: periodic sticky request, arbiter grant, refresh command
// sequence. Define SDRAM_AREF_PRECHARGE_EN to prefix each refresh with PRECHARGE-all.
module sdram_aref #(
    parameter int ADDR_WIDTH = 12,
    parameter int REF_PERIOD = 750,
    parameter int TRP_CYCLES = 2,
    parameter int TRC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_aref_if.slave bus
);

    localparam int CNT_W    = $clog2(REF_PERIOD + 1);
    localparam int WAIT_MAX = (TRP_CYCLES > TRC_CYCLES) ? TRP_CYCLES : TRC_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;
`ifdef SDRAM_AREF_PRECHARGE_EN
    localparam logic [3:0] CMD_PRE  = 4'b0010;
`endif
    localparam logic [ADDR_WIDTH-1:0] ADDR_PALL = ADDR_WIDTH'(11'd1024);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
`ifdef SDRAM_AREF_PRECHARGE_EN
        ST_PRE       = 3'd1,
        ST_PRE_WAIT  = 3'd2,
`endif
        ST_AREF      = 3'd3,
        ST_AREF_WAIT = 3'd4,
        ST_END       = 3'd5
    } state_t;

    logic [CNT_W-1:0]  cnt_r;
    logic              wrap_s;
    logic              grant_s;
    logic              req_r;
    state_t            state_r;
    state_t            state_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_s;
    logic [3:0]        cmd_s;
    logic              end_s;
    logic [3:0]        cmd_r;
    logic              end_r;

    assign wrap_s  = bus.init_end && (cnt_r == CNT_W'(REF_PERIOD - 1));
    assign grant_s = (state_r == ST_IDLE) && req_r && bus.aref_en;

    // Free-running refresh period counter, held at zero until the SDRAM is initialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.init_end || wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Sticky request: a fresh wrap outranks the grant that consumes the previous request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r <= 1'b0;
        end else if (!bus.init_end) begin
            req_r <= 1'b0;
        end else if (wrap_s) begin
            req_r <= 1'b1;
        end else if (grant_s) begin
            req_r <= 1'b0;
        end else begin
            req_r <= req_r;
        end
    end

    // Sequence state and wait-cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wait_r  <= {WAIT_W{1'b0}};
        end else begin
            state_r <= state_s;
            wait_r  <= wait_s;
        end
    end

    // Next-state logic and the command belonging to the current state.
    always_comb begin
        state_s = state_r;
        wait_s  = {WAIT_W{1'b0}};
        cmd_s   = CMD_NOP;
        end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
`ifdef SDRAM_AREF_PRECHARGE_EN
                    state_s = ST_PRE;
`else
                    state_s = ST_AREF;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef SDRAM_AREF_PRECHARGE_EN
            ST_PRE: begin
                cmd_s   = CMD_PRE;
                state_s = ST_PRE_WAIT;
            end
            ST_PRE_WAIT: begin
                if (wait_r == WAIT_W'(TRP_CYCLES - 1)) begin
                    state_s = ST_AREF;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                    state_s = ST_PRE_WAIT;
                end
            end
`endif
            ST_AREF: begin
                cmd_s   = CMD_AREF;
                state_s = ST_AREF_WAIT;
            end
            ST_AREF_WAIT: begin
                if (wait_r == WAIT_W'(TRC_CYCLES - 1)) begin
                    state_s = ST_END;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                    state_s = ST_AREF_WAIT;
                end
            end
            ST_END: begin
                end_s   = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered command and completion outputs, one cycle behind the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r <= CMD_NOP;
            end_r <= 1'b0;
        end else begin
            cmd_r <= cmd_s;
            end_r <= end_s;
        end
    end

    assign bus.aref_req  = req_r;
    assign bus.aref_end  = end_r;
    assign bus.aref_cmd  = cmd_r;
    assign bus.aref_addr = ADDR_PALL;

endmodule

// File: tb/tb_sdram_aref.sv
// Randomised bench for sdram_aref: two instances (default period and period 8) compared
// every cycle against a queue/table reference model, plus literal timing expectations.
module tb_sdram_aref;

    localparam int AW  = 12;
    localparam int TRP = 2;
    localparam int TRC = 4;
    localparam logic [AW-1:0] ADDR_EXP = 12'b0100_0000_0000;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PREC = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
`ifdef SDRAM_AREF_PRECHARGE_EN
    localparam int LIT_LEN = 9;
    logic [3:0] lit_cmd [LIT_LEN] = '{PREC, NOP, NOP, AREF, NOP, NOP, NOP, NOP, NOP};
`else
    localparam int LIT_LEN = 6;
    logic [3:0] lit_cmd [LIT_LEN] = '{AREF, NOP, NOP, NOP, NOP, NOP};
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    int         per [2] = '{750, 8};
    int         phase [2];
    bit         req [2];
    int         left [2];
    logic [4:0] exp_o [2];
    bit         init [2];
    bit         en [2];
    logic [4:0] seq_tab [$];

    always #5 clk = ~clk;

    sdram_aref_if #(.ADDR_WIDTH(AW)) bus_a ();
    sdram_aref_if #(.ADDR_WIDTH(AW)) bus_b ();

    sdram_aref #(.ADDR_WIDTH(AW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sdram_aref #(.ADDR_WIDTH(AW), .REF_PERIOD(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    function automatic logic [17:0] dut_out(input int i);
        if (i == 0) return {bus_a.aref_req, bus_a.aref_end, bus_a.aref_cmd, bus_a.aref_addr};
        return {bus_b.aref_req, bus_b.aref_end, bus_b.aref_cmd, bus_b.aref_addr};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference: period phase, sticky request, and a countdown into the command table.
    task automatic step_model(input int i);
        bit idle;
        bit grant;
        bit wrap;
        if (!rst_n) begin
            phase[i] = 0;
            req[i]   = 1'b0;
            left[i]  = 0;
            exp_o[i] = {1'b0, NOP};
        end else begin
            idle  = (left[i] == 0);
            grant = idle && req[i] && en[i];
            wrap  = init[i] && (phase[i] == per[i] - 1);
            phase[i] = !init[i] ? 0 : (wrap ? 0 : phase[i] + 1);
            req[i]   = !init[i] ? 1'b0 : (wrap ? 1'b1 : (grant ? 1'b0 : req[i]));
            if (left[i] > 0) begin
                exp_o[i] = seq_tab[seq_tab.size() - left[i]];
                left[i]--;
            end else begin
                exp_o[i] = {1'b0, NOP};
            end
            if (grant) left[i] = seq_tab.size();
        end
    endtask

    task automatic check_model(input int i);
        logic [17:0] got;
        logic [17:0] want;
        got  = dut_out(i);
        want = {req[i], exp_o[i], ADDR_EXP};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL model_cmp dut%0d t=%0t: got req/end/cmd/addr %b, expected %b",
                     i, $time, got, want);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        bus_a.init_end = init[0];
        bus_a.aref_en  = en[0];
        bus_b.init_end = init[1];
        bus_b.aref_en  = en[1];
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            step_model(i);
            check_model(i);
        end
    endtask

    initial begin
        int first_a;
        int first_b;
        int ends;
        int waited;

`ifdef SDRAM_AREF_PRECHARGE_EN
        seq_tab.push_back({1'b0, PREC});
        for (int k = 0; k < TRP; k++) seq_tab.push_back({1'b0, NOP});
`endif
        seq_tab.push_back({1'b0, AREF});
        for (int k = 0; k < TRC; k++) seq_tab.push_back({1'b0, NOP});
        seq_tab.push_back({1'b1, NOP});

        init = '{1'b1, 1'b1};
        en   = '{1'b0, 1'b0};
        bus_a.init_end = 1'b1;
        bus_a.aref_en  = 1'b0;
        bus_b.init_end = 1'b1;
        bus_b.aref_en  = 1'b0;

        // reset state
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_cmd", int'(bus_a.aref_cmd), int'(NOP));
        chk("rst_req", int'(bus_a.aref_req), 0);
        chk("rst_end", int'(bus_a.aref_end), 0);
        chk("seq_len", seq_tab.size(), LIT_LEN);
        rst_n = 1'b1;

        // first request timing with grants withheld
        first_a = -1;
        first_b = -1;
        for (int n = 1; n <= 760; n++) begin
            cycle();
            if (first_a < 0 && bus_a.aref_req) first_a = n;
            if (first_b < 0 && bus_b.aref_req) first_b = n;
        end
        chk("req_rise_a", first_a, 750);
        chk("req_rise_b", first_b, 8);
        chk("req_held_b", int'(bus_b.aref_req), 1);

        // directed grant on the default instance, with stray grants mid-sequence
        en[0] = 1'b1;
        cycle();
        chk("req_clr_on_grant", int'(bus_a.aref_req), 0);
        ends = 0;
        for (int k = 0; k < LIT_LEN + 4; k++) begin
            en[0] = (k >= 1);
            cycle();
            if (k < LIT_LEN) chk($sformatf("seq_cmd_%0d", k), int'(bus_a.aref_cmd), int'(lit_cmd[k]));
            if (bus_a.aref_end) ends++;
            if (k == LIT_LEN - 1) chk("end_pulse_pos", int'(bus_a.aref_end), 1);
        end
        chk("end_count", ends, 1);
        chk("idle_cmd", int'(bus_a.aref_cmd), int'(NOP));

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 299) == 0) init[i] = !init[i];
            end
            en[0] = ($urandom_range(0, 3) == 0);
            en[1] = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // asynchronous reset while the period-8 instance is in AREF_WAIT
        init = '{1'b1, 1'b1};
        en   = '{1'b0, 1'b1};
        waited = 0;
        while (left[1] != TRC && waited < 100) begin
            cycle();
            waited++;
        end
        if (left[1] != TRC) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_aref_wait: got left=%0d after %0d cycles, expected %0d", left[1], waited, TRC);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd", int'(bus_b.aref_cmd), int'(NOP));
        chk("arst_req", int'(bus_b.aref_req), 0);
        chk("arst_end", int'(bus_b.aref_end), 0);
        en[1] = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        rst_n = 1'b1;
        first_b = -1;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (first_b < 0 && bus_b.aref_req) first_b = n;
        end
        chk("req_rise_after_rst", first_b, 8);

        for (int n = 0; n < 300; n++) begin
            en[0] = ($urandom_range(0, 1) == 0);
            en[1] = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
